psm_multileg: RTL

PSM_MULTILEG -- requirements
Module: psm_multileg

---
 rtl/psm_multileg_if.sv | 29 ++
 rtl/psm_multileg.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/psm_multileg_if.sv
// Signal bundle for the phase-shifted multi-leg modulator.
// Carries the control inputs and the gate/status outputs between a controller and the modulator.
interface psm_multileg_if #(
   parameter int CNT_W = 16,
   parameter int N_LEG = 4,
   parameter int DT_W  = 8
);
   // load is a one-cycle request with no back-pressure. load_ack pulses later, in the
   // first cycle the captured set is active. A second load before that ack replaces the first.
   logic                   en;
   logic [CNT_W-1:0]       period;
   logic [N_LEG*CNT_W-1:0] phase;
   logic [DT_W-1:0]        deadtime;
   logic                   load;
   logic                   sync;
   logic [2*N_LEG-1:0]     psm;
   logic                   period_start;
   logic                   load_ack;

   modport master (
      output en, period, phase, deadtime, load, sync,
      input  psm, period_start, load_ack
   );

   modport slave (
      input  en, period, phase, deadtime, load, sync,
      output psm, period_start, load_ack
   );
endinterface

// File: rtl/psm_multileg.sv
// Phase-shifted multi-leg modulator: a shared carrier counter, a per-leg phase-shifted
// 50% reference, and a per-leg deadtime FSM that drives complementary gate pairs.
module psm_multileg #(
   parameter int CNT_W = 16,
   parameter int N_LEG = 4,
   parameter int DT_W  = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   iEN,
   input  logic [CNT_W-1:0]       iPERIOD,
   input  logic [N_LEG*CNT_W-1:0] iPHASE,
   input  logic [DT_W-1:0]        iDEADTIME,
   input  logic                   iLOAD,
   input  logic                   iSYNC,
   output logic [2*N_LEG-1:0]     oPSM,
   output logic                   oPERIOD_START,
   output logic                   oLOAD_ACK
);

   localparam int MW = (CNT_W > DT_W) ? CNT_W : DT_W;

   typedef enum logic [1:0] {
      ST_OFF,
      ST_WAIT,
      ST_ON_H,
      ST_ON_L
   } leg_st_e;

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       pa_q, pa_d;
   logic [N_LEG*CNT_W-1:0] ph_q, ph_d;
   logic [DT_W-1:0]        dt_q, dt_d;
   logic [CNT_W-1:0]       pend_per_q, pend_per_d;
   logic [N_LEG*CNT_W-1:0] pend_ph_q, pend_ph_d;
   logic [DT_W-1:0]        pend_dt_q, pend_dt_d;
   logic                   pend_flag_q, pend_flag_d;
   logic [N_LEG-1:0]       ref_q, ref_d;
   logic [N_LEG-1:0]       ref_prev_q;
   logic                   ps_q, ps_d;
   logic                   ack_q, ack_d;
   logic                   wrap;
   logic                   act_upd;
   logic [CNT_W-1:0]       src_per;
   logic [N_LEG*CNT_W-1:0] src_ph;
   logic [DT_W-1:0]        src_dt;

   leg_st_e                st_q [N_LEG];
   logic [DT_W-1:0]        dtc_q [N_LEG];
   logic [2*N_LEG-1:0]     psm_q;

   function automatic logic [CNT_W-1:0] clamp_per(input logic [CNT_W-1:0] p);
      return (p < CNT_W'(4)) ? CNT_W'(4) : p;
   endfunction

   function automatic logic [CNT_W-1:0] clamp_ph(input logic [CNT_W-1:0] ph,
                                                 input logic [CNT_W-1:0] pa);
      return (ph > pa - CNT_W'(1)) ? pa - CNT_W'(1) : ph;
   endfunction

   function automatic logic [DT_W-1:0] clamp_dt(input logic [DT_W-1:0]  dt,
                                                input logic [CNT_W-1:0] pa);
      logic [MW-1:0] lim;
      logic [MW-1:0] dtw;
      lim = MW'((pa >> 1) - CNT_W'(1));
      dtw = MW'(dt);
      return (dtw > lim) ? DT_W'(lim) : dt;
   endfunction

   // Subtracting (ph - cnt) from pa keeps the wrapped distance inside CNT_W bits.
   function automatic logic ref_of(input logic [CNT_W-1:0] cnt,
                                   input logic [CNT_W-1:0] pa,
                                   input logic [CNT_W-1:0] ph);
      logic [CNT_W-1:0] s;
      if (cnt >= ph) s = cnt - ph;
      else           s = pa - (ph - cnt);
      return s < (pa >> 1);
   endfunction

   always_comb begin
      wrap    = !RST && iEN && (iSYNC || (cnt_q == pa_q - CNT_W'(1)));
      cnt_d   = (RST || !iEN || wrap) ? '0 : cnt_q + CNT_W'(1);
      ps_d    = !RST && iEN && (cnt_d == '0);
      ack_d   = wrap && pend_flag_q;
      act_upd = RST || (wrap && pend_flag_q);
   end

   // A load coincident with a wrap refills the pending set after the old one is consumed.
   always_comb begin
      pend_per_d  = pend_per_q;
      pend_ph_d   = pend_ph_q;
      pend_dt_d   = pend_dt_q;
      pend_flag_d = pend_flag_q;
      if (RST) begin
         pend_flag_d = 1'b0;
      end else if (iLOAD) begin
         pend_per_d  = iPERIOD;
         pend_ph_d   = iPHASE;
         pend_dt_d   = iDEADTIME;
         pend_flag_d = 1'b1;
      end else if (wrap) begin
         pend_flag_d = 1'b0;
      end
   end

   assign src_per = RST ? iPERIOD   : pend_per_q;
   assign src_ph  = RST ? iPHASE    : pend_ph_q;
   assign src_dt  = RST ? iDEADTIME : pend_dt_q;

   always_comb begin
      pa_d = pa_q;
      ph_d = ph_q;
      dt_d = dt_q;
      if (act_upd) begin
         pa_d = clamp_per(src_per);
         for (int i = 0; i < N_LEG; i++) begin
            ph_d[i*CNT_W +: CNT_W] = clamp_ph(src_ph[i*CNT_W +: CNT_W], pa_d);
         end
         dt_d = clamp_dt(src_dt, pa_d);
      end
   end

   always_comb begin
      ref_d = '0;
      for (int i = 0; i < N_LEG; i++) begin
         ref_d[i] = ref_of(cnt_q, pa_q, ph_q[i*CNT_W +: CNT_W]);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q       <= '0;
         pend_flag_q <= 1'b0;
         ref_q       <= '0;
         ref_prev_q  <= '0;
         ps_q        <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         pend_flag_q <= pend_flag_d;
         ref_q       <= ref_d;
         ref_prev_q  <= ref_q;
         ps_q        <= ps_d;
         ack_q       <= ack_d;
      end
      pa_q       <= pa_d;
      ph_q       <= ph_d;
      dt_q       <= dt_d;
      pend_per_q <= pend_per_d;
      pend_ph_q  <= pend_ph_d;
      pend_dt_q  <= pend_dt_d;
   end

   // Gate pair encoding per leg: 2'b01 high-side on, 2'b10 low-side on, 2'b00 both off.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < N_LEG; i++) begin
         if (RST || !iEN) begin
            st_q[i]          <= ST_OFF;
            dtc_q[i]         <= '0;
            psm_q[2*i +: 2]  <= 2'b00;
         end else if ((st_q[i] == ST_OFF) || (ref_q[i] != ref_prev_q[i])) begin
            if (dt_q == '0) begin
               st_q[i]         <= ref_q[i] ? ST_ON_H : ST_ON_L;
               psm_q[2*i +: 2] <= ref_q[i] ? 2'b01 : 2'b10;
            end else begin
               st_q[i]         <= ST_WAIT;
               dtc_q[i]        <= dt_q - DT_W'(1);
               psm_q[2*i +: 2] <= 2'b00;
            end
         end else if (st_q[i] == ST_WAIT) begin
            if (dtc_q[i] == '0) begin
               st_q[i]         <= ref_q[i] ? ST_ON_H : ST_ON_L;
               psm_q[2*i +: 2] <= ref_q[i] ? 2'b01 : 2'b10;
            end else begin
               dtc_q[i]        <= dtc_q[i] - DT_W'(1);
            end
         end
      end
   end

   assign oPSM          = psm_q;
   assign oPERIOD_START = ps_q;
   assign oLOAD_ACK     = ack_q;

endmodule
